// File: rtl/gx_reconfig_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gx_reconfig_arbiter
// Purpose  : Shares the single Avalon-MM reconfiguration port of a GX
//            transceiver bank between N_REQ per-channel requesters.
//            Arbitration is round-robin with one transaction in flight.
//            A requester is skipped while its channel reports cal_busy.
//            Requester i always targets channel i: bank address =
//            {i[2:0], offset}.
// Ports    : reconfig_clk/reconfig_reset  - clock, synchronous active-high reset
//            req_*                         - N_REQ Avalon-MM slave ports (packed)
//            cal_busy                      - per-channel calibration busy
//            reconfig_*                    - Avalon-MM master to transceiver
//            grant_id, arb_busy            - status
//            timeout_err                   - one-cycle pulse on watchdog abort
// Options  : `define GX_RECONF_ARB_TIMEOUT_EN enables the ISSUE-state watchdog
//            (TIMEOUT_CYCLES). Without it ISSUE waits indefinitely and
//            timeout_err is tied 0.
// Revision : 1.0 - initial release
// ============================================================================
module gx_reconfig_arbiter #(
    parameter int N_REQ          = 6,
    parameter int OFFSET_W       = 10,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      reconfig_clk,
    input  logic                      reconfig_reset,
    input  logic [N_REQ-1:0]          req_write,
    input  logic [N_REQ-1:0]          req_read,
    input  logic [N_REQ*OFFSET_W-1:0] req_address,
    input  logic [N_REQ*32-1:0]       req_writedata,
    output logic [N_REQ-1:0]          req_waitrequest,
    output logic [31:0]               req_readdata,
    input  logic [N_REQ-1:0]          cal_busy,
    output logic                      reconfig_write,
    output logic                      reconfig_read,
    output logic [OFFSET_W+2:0]       reconfig_address,
    output logic [31:0]               reconfig_writedata,
    input  logic [31:0]               reconfig_readdata,
    input  logic                      reconfig_waitrequest,
    output logic [2:0]                grant_id,
    output logic                      arb_busy,
    output logic                      timeout_err
);

    if (N_REQ < 1 || N_REQ > 8 || OFFSET_W < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("gx_reconfig_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                state_q;
    logic [2:0]            ptr_q;
    logic [2:0]            grant_q;
    logic [N_REQ-1:0]      waitreq_q;
    logic [31:0]           rdata_q;
    logic                  wr_q;
    logic                  rd_q;
    logic [OFFSET_W+2:0]   addr_q;
    logic [31:0]           wdata_q;
    logic                  busy_q;

    // ------------------------------------------------------------------
    // Round-robin selection: scan from ptr_q upward with wrap. The scan
    // runs from the far end toward ptr_q so the closest hit is the last
    // assignment and wins.
    // ------------------------------------------------------------------
    logic [N_REQ-1:0]      eligible;
    logic [15:0]           elig_pad;
    logic [3:0]            scan_idx;
    logic                  sel_hit;
    logic [2:0]            sel_idx;

    assign eligible = (req_write | req_read) & ~cal_busy;
    assign elig_pad = 16'(eligible);

    always_comb begin
        sel_hit  = 1'b0;
        sel_idx  = 3'd0;
        scan_idx = 4'd0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, ptr_q} + 4'(k);
            if (scan_idx >= 4'(N_REQ)) begin
                scan_idx = scan_idx - 4'(N_REQ);
            end
            if (elig_pad[scan_idx]) begin
                sel_hit = 1'b1;
                sel_idx = scan_idx[2:0];
            end
        end
    end

    // Mux the selected requester's strobes/address/data with constant slices.
    logic                  sel_wr;
    logic                  sel_rd;
    logic [OFFSET_W-1:0]   sel_off;
    logic [31:0]           sel_wdata;

    always_comb begin
        sel_wr    = 1'b0;
        sel_rd    = 1'b0;
        sel_off   = '0;
        sel_wdata = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (sel_idx == 3'(j)) begin
                sel_wr    = req_write[j];
                sel_rd    = req_read[j];
                sel_off   = req_address[j*OFFSET_W +: OFFSET_W];
                sel_wdata = req_writedata[j*32 +: 32];
            end
        end
    end

    logic [N_REQ-1:0]      grant_onehot;
    logic [2:0]            ptr_next;

    always_comb begin
        grant_onehot = '0;
        for (int j = 0; j < N_REQ; j++) begin
            grant_onehot[j] = (grant_q == 3'(j));
        end
    end

    assign ptr_next = (({1'b0, grant_q} + 4'd1) >= 4'(N_REQ)) ? 3'd0 : grant_q + 3'd1;

`ifdef GX_RECONF_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]      tmo_cnt_q;
    logic                  terr_q;
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge reconfig_clk) begin
        if (reconfig_reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 3'd0;
            grant_q   <= 3'd0;
            waitreq_q <= '1;
            rdata_q   <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
`ifdef GX_RECONF_ARB_TIMEOUT_EN
            tmo_cnt_q <= '0;
            terr_q    <= 1'b0;
`endif
        end else begin
`ifdef GX_RECONF_ARB_TIMEOUT_EN
            terr_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (sel_hit) begin
                        state_q <= ST_ISSUE;
                        grant_q <= sel_idx;
                        addr_q  <= {sel_idx, sel_off};
                        wdata_q <= sel_wdata;
                        // Simultaneous read and write is executed as a write.
                        wr_q    <= sel_wr;
                        rd_q    <= sel_rd & ~sel_wr;
                        busy_q  <= 1'b1;
`ifdef GX_RECONF_ARB_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end
                end

                ST_ISSUE: begin
                    if (!reconfig_waitrequest) begin
                        if (rd_q) begin
                            rdata_q <= reconfig_readdata;
                        end
                        wr_q      <= 1'b0;
                        rd_q      <= 1'b0;
                        waitreq_q <= ~grant_onehot;
                        state_q   <= ST_RESP;
                    end
`ifdef GX_RECONF_ARB_TIMEOUT_EN
                    else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Slave never answered: abort and hand back a marker word.
                        wr_q      <= 1'b0;
                        rd_q      <= 1'b0;
                        rdata_q   <= 32'hDEAD_BEEF;
                        waitreq_q <= ~grant_onehot;
                        terr_q    <= 1'b1;
                        state_q   <= ST_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    end
`endif
                end

                ST_RESP: begin
                    waitreq_q <= '1;
                    ptr_q     <= ptr_next;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_waitrequest    = waitreq_q;
    assign req_readdata       = rdata_q;
    assign reconfig_write     = wr_q;
    assign reconfig_read      = rd_q;
    assign reconfig_address   = addr_q;
    assign reconfig_writedata = wdata_q;
    assign grant_id           = grant_q;
    assign arb_busy           = busy_q;

endmodule
`default_nettype wire
